// File: rtl/uart_mux_pkg.sv
// Shared types and constants for the UART egress arbiter.
package uart_mux_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } state_t;

   localparam logic [7:0] TAG_BASE_DEFAULT = 8'hA0;

   localparam int SRC_APP_RESP = 0;
   localparam int SRC_ETH_PHY  = 1;
   localparam int SRC_FRAME    = 2;

   // Header byte for a source: base has its low 3 bits clear, so OR acts as add.
   function automatic logic [7:0] make_tag(input logic [7:0] base, input logic [2:0] idx);
      return base | {5'b00000, idx};
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int IDX_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx
);

   // Index ptr+off reduced modulo NUM_SRC (off never exceeds NUM_SRC).
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_SRC) begin
         sum = sum - NUM_SRC;
      end
      return IDX_W'(sum);
   endfunction

   logic found;

   // Scan ptr+1 .. ptr+NUM_SRC and take the first asserted request.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         if (!found && req[wrap_add(ptr, i)]) begin
            found                = 1'b1;
            gnt[wrap_add(ptr, i)] = 1'b1;
            gnt_idx              = wrap_add(ptr, i);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin mux of byte streams onto one UART egress
// stream, prefixing each packet with a tag byte naming its source.
module uart_tx_arbiter
   import uart_mux_pkg::*;
#(
   parameter int         DATA_WIDTH = 8,
   parameter int         NUM_SRC    = 3,
   parameter logic [7:0] TAG_BASE   = TAG_BASE_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_SRC-1:0]            s_tvalid,
   input  logic [NUM_SRC-1:0]            s_tlast,
   output logic [NUM_SRC-1:0]            s_tready,
   output logic [DATA_WIDTH-1:0]         m_tdata,
   output logic                          m_tvalid,
   output logic                          m_tlast,
   input  logic                          m_tready,
   output logic [NUM_SRC-1:0]            grant,
   output logic                          pkt_done
);

   localparam int IDX_W = $clog2(NUM_SRC);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       gidx_q, gidx_d;
   logic [NUM_SRC-1:0]     grant_q, grant_d;
   logic                   m_tvalid_q, m_tvalid_d;
   logic [DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
   logic                   m_tlast_q, m_tlast_d;

   logic                   slot_free;
   logic [NUM_SRC-1:0]     arb_gnt;
   logic [IDX_W-1:0]       arb_idx;
   logic [DATA_WIDTH-1:0]  src_data [NUM_SRC];

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
      assign src_data[k] = s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
   end

   // The single output register can take a new byte when empty or draining.
   assign slot_free = !m_tvalid_q || m_tready;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req     (s_tvalid),
      .ptr     (ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   // Next-state: arbitrate and emit the tag in IDLE, stream the owner's bytes in DATA.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gidx_d     = gidx_q;
      grant_d    = grant_q;
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      m_tlast_d  = m_tlast_q;
      s_tready   = '0;
      pkt_done   = 1'b0;

      if (slot_free) begin
         m_tvalid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (slot_free && (|s_tvalid)) begin
               m_tvalid_d = 1'b1;
               m_tdata_d  = make_tag(TAG_BASE, 3'(arb_idx));
               m_tlast_d  = 1'b0;
               grant_d    = arb_gnt;
               gidx_d     = arb_idx;
               state_d    = ST_DATA;
            end
         end
         ST_DATA: begin
            // Only the owner sees ready; its ready mirrors slot_free combinationally.
            s_tready[gidx_q] = slot_free;
            if (slot_free && s_tvalid[gidx_q]) begin
               m_tvalid_d = 1'b1;
               m_tdata_d  = src_data[gidx_q];
               m_tlast_d  = s_tlast[gidx_q];
               if (s_tlast[gidx_q]) begin
                  ptr_d    = gidx_q;
                  grant_d  = '0;
                  pkt_done = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any packet in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= IDX_W'(NUM_SRC - 1);
         gidx_q     <= '0;
         grant_q    <= '0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tlast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gidx_q     <= gidx_d;
         grant_q    <= grant_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tlast_q  <= m_tlast_d;
      end
   end

   assign m_tvalid = m_tvalid_q;
   assign m_tdata  = m_tdata_q;
   assign m_tlast  = m_tlast_q;
   assign grant    = grant_q;

endmodule
